cva6_pma_region_unit: RTL and testbench

// Runtime-programmable physical-memory-attribute table; successor to the static per-core region lists.

---
 rtl/cva6_pma_region_unit.sv | 177 +++++++++++++++++
 tb/tb_cva6_pma_region_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_pma_region_unit.sv
// rtl/cva6_pma_region_unit.sv - runtime-programmable PMA region table with registered lookups
module cva6_pma_region_unit #(
  parameter int unsigned          NrRules   = 4,
  parameter int unsigned          NrPorts   = 2,
  parameter int unsigned          AddrWidth = 64,
  parameter logic [AddrWidth-1:0] RstBase [NrRules] = '{64'h8000_0000, 64'h1_0000, 64'h0, 64'h0},
  parameter logic [AddrWidth-1:0] RstLen  [NrRules] = '{64'h4000_0000, 64'h1_0000, 64'h1000, 64'h0},
  parameter logic [3:0]           RstAttr [NrRules] = '{4'b1110, 4'b1000, 4'b1001, 4'b0000},
  parameter logic [3:0]           DefaultAttr = 4'b0001,
  localparam int unsigned         IdxW = $clog2(NrRules) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [IdxW-1:0]              cfg_idx_i,
  input  logic [1:0]                   cfg_field_i,
  input  logic [AddrWidth-1:0]         cfg_wdata_i,
  output logic                         cfg_rvalid_o,
  output logic [AddrWidth-1:0]         cfg_rdata_o,
  output logic                         cfg_err_o,
  output logic                         cfg_update_o,
  input  logic [NrPorts-1:0]           lkp_valid_i,
  input  logic [NrPorts*AddrWidth-1:0] lkp_addr_i,
  output logic [NrPorts-1:0]           lkp_valid_o,
  output logic [NrPorts-1:0]           lkp_hit_o,
  output logic [NrPorts*4-1:0]         lkp_rule_o,
  output logic [NrPorts*4-1:0]         lkp_attr_o
);

  localparam logic [IdxW-1:0] NrRulesIdx = IdxW'(NrRules);

  localparam logic [1:0] FieldBase = 2'd0;
  localparam logic [1:0] FieldLen  = 2'd1;
  localparam logic [1:0] FieldAttr = 2'd2;

  // Region table
  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [3:0]           attr_q [NrRules];
  logic [NrRules-1:0]   lock_q;

  // Config decode results
  logic                 sel_lock;
  logic [AddrWidth-1:0] sel_rdata;
  logic                 cfg_bad;
  logic                 cfg_wr_ok;

  // Config response registers
  logic                 rvalid_q;
  logic [AddrWidth-1:0] rdata_q;
  logic                 err_q;
  logic                 update_q;

  // Lookup match results and registered outputs
  logic [NrPorts-1:0]       m_hit;
  logic [NrPorts-1:0][3:0]  m_rule;
  logic [NrPorts-1:0][3:0]  m_attr;
  logic [NrPorts-1:0]       lvalid_q;
  logic [NrPorts-1:0]       lhit_q;
  logic [NrPorts-1:0][3:0]  lrule_q;
  logic [NrPorts-1:0][3:0]  lattr_q;

  // Range test; the end is computed one bit wider so a range touching the top never wraps
  function automatic logic in_range(input logic [AddrWidth-1:0] addr,
                                    input logic [AddrWidth-1:0] base,
                                    input logic [AddrWidth-1:0] len);
    logic [AddrWidth:0] lim;
    lim = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < lim);
  endfunction

  // Decode the config access: select the addressed rule, form read data and classify errors
  always_comb begin
    sel_lock  = 1'b0;
    sel_rdata = '0;
    for (int r = 0; r < int'(NrRules); r++) begin
      if (cfg_idx_i == IdxW'(r)) begin
        sel_lock = lock_q[r];
        case (cfg_field_i)
          FieldBase: sel_rdata = base_q[r];
          FieldLen:  sel_rdata = len_q[r];
          FieldAttr: sel_rdata = {{(AddrWidth-8){1'b0}}, lock_q[r], 3'b000, attr_q[r]};
          default:   sel_rdata = '0;
        endcase
      end
    end
    cfg_bad   = (cfg_idx_i >= NrRulesIdx) || (cfg_field_i == 2'd3) || (cfg_we_i && sel_lock);
    cfg_wr_ok = cfg_req_i && cfg_we_i && !cfg_bad;
  end

  // Table storage: reset image, then accepted writes; lock only ever sets
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < int'(NrRules); r++) begin
        base_q[r] <= RstBase[r];
        len_q[r]  <= RstLen[r];
        attr_q[r] <= RstAttr[r];
      end
      lock_q <= '0;
    end else if (cfg_wr_ok) begin
      for (int r = 0; r < int'(NrRules); r++) begin
        if (cfg_idx_i == IdxW'(r)) begin
          case (cfg_field_i)
            FieldBase: base_q[r] <= cfg_wdata_i;
            FieldLen:  len_q[r]  <= cfg_wdata_i;
            FieldAttr: begin
              attr_q[r] <= cfg_wdata_i[3:0];
              lock_q[r] <= lock_q[r] | cfg_wdata_i[7];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Config response: every request answered one cycle later; rdata only for clean reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      rvalid_q <= cfg_req_i;
      err_q    <= cfg_req_i && cfg_bad;
      rdata_q  <= (cfg_req_i && !cfg_we_i && !cfg_bad) ? sel_rdata : '0;
      update_q <= cfg_wr_ok;
    end
  end

  // Per-port priority match; walking from the highest index down lets the lowest index win
  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++) begin
      m_hit[p]  = 1'b0;
      m_rule[p] = 4'd0;
      m_attr[p] = DefaultAttr;
      for (int r = int'(NrRules) - 1; r >= 0; r--) begin
        if (in_range(lkp_addr_i[p*AddrWidth +: AddrWidth], base_q[r], len_q[r])) begin
          m_hit[p]  = 1'b1;
          m_rule[p] = 4'(r);
          m_attr[p] = attr_q[r];
        end
      end
    end
  end

  // Lookup result registers: valid follows the request, payload holds between requests
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvalid_q <= '0;
      lhit_q   <= '0;
      lrule_q  <= '0;
      lattr_q  <= {NrPorts{DefaultAttr}};
    end else begin
      lvalid_q <= lkp_valid_i;
      for (int p = 0; p < int'(NrPorts); p++) begin
        if (lkp_valid_i[p]) begin
          lhit_q[p]  <= m_hit[p];
          lrule_q[p] <= m_rule[p];
          lattr_q[p] <= m_attr[p];
        end
      end
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_err_o    = err_q;
  assign cfg_update_o = update_q;
  assign lkp_valid_o  = lvalid_q;
  assign lkp_hit_o    = lhit_q;
  assign lkp_rule_o   = lrule_q;
  assign lkp_attr_o   = lattr_q;

endmodule

// File: tb/tb_cva6_pma_region_unit.sv
// tb/tb_cva6_pma_region_unit.sv - directed scoreboard bench for cva6_pma_region_unit
module tb_cva6_pma_region_unit;

  localparam int NP = 2;
  localparam int AW = 64;

  typedef struct packed {
    logic       hit;
    logic [3:0] rule;
    logic [3:0] attr;
  } lkp_exp_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic        upd;
  } cfg_exp_t;

  localparam lkp_exp_t RST_LKP = '{hit: 1'b0, rule: 4'd0, attr: 4'b0001};

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_req = 1'b0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_idx = '0;
  logic [1:0]       cfg_field = '0;
  logic [63:0]      cfg_wdata = '0;
  logic             cfg_rvalid;
  logic [63:0]      cfg_rdata;
  logic             cfg_err;
  logic             cfg_update;
  logic [NP-1:0]    lkp_valid = '0;
  logic [NP*AW-1:0] lkp_addr = '0;
  logic [NP-1:0]    lkp_valid_o;
  logic [NP-1:0]    lkp_hit_o;
  logic [NP*4-1:0]  lkp_rule_o;
  logic [NP*4-1:0]  lkp_attr_o;

  lkp_exp_t q_lkp0[$];
  lkp_exp_t q_lkp1[$];
  cfg_exp_t q_cfg[$];
  lkp_exp_t last0 = RST_LKP;
  lkp_exp_t last1 = RST_LKP;

  int n_cmp  = 0;
  int n_fail = 0;

  cva6_pma_region_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_field_i  (cfg_field),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_err_o    (cfg_err),
    .cfg_update_o (cfg_update),
    .lkp_valid_i  (lkp_valid),
    .lkp_addr_i   (lkp_addr),
    .lkp_valid_o  (lkp_valid_o),
    .lkp_hit_o    (lkp_hit_o),
    .lkp_rule_o   (lkp_rule_o),
    .lkp_attr_o   (lkp_attr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_lkp(input int p, input lkp_exp_t e);
    chk($sformatf("lkp%0d_hit", p),  64'(lkp_hit_o[p]),        64'(e.hit));
    chk($sformatf("lkp%0d_rule", p), 64'(lkp_rule_o[p*4 +: 4]), 64'(e.rule));
    chk($sformatf("lkp%0d_attr", p), 64'(lkp_attr_o[p*4 +: 4]), 64'(e.attr));
  endtask

  task automatic drive_cfg(input logic we, input logic [2:0] idx, input logic [1:0] field,
                           input logic [63:0] wdata, input logic [63:0] exp_rdata,
                           input logic exp_err);
    cfg_exp_t e;
    cfg_req   = 1'b1;
    cfg_we    = we;
    cfg_idx   = idx;
    cfg_field = field;
    cfg_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.upd   = we && !exp_err;
    q_cfg.push_back(e);
  endtask

  task automatic drive_lkp(input int p, input logic [63:0] addr, input logic hit,
                           input logic [3:0] rule, input logic [3:0] attr);
    lkp_exp_t e;
    lkp_valid[p] = 1'b1;
    lkp_addr[p*AW +: AW] = addr;
    e.hit  = hit;
    e.rule = rule;
    e.attr = attr;
    if (p == 0) q_lkp0.push_back(e);
    else        q_lkp1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_req   = 1'b0;
    cfg_we    = 1'b0;
    lkp_valid = '0;
  endtask

  // Scoreboard: pop on every produced result and check held payload on idle cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = RST_LKP;
      last1 = RST_LKP;
    end else begin
      if (lkp_valid_o[0]) begin
        n_cmp++;
        assert (q_lkp0.size() > 0) else begin
          n_fail++;
          $error("FAIL lkp0_unexpected: observed valid=1 expected no result");
        end
        if (q_lkp0.size() > 0) last0 = q_lkp0.pop_front();
      end
      chk_lkp(0, last0);
      if (lkp_valid_o[1]) begin
        n_cmp++;
        assert (q_lkp1.size() > 0) else begin
          n_fail++;
          $error("FAIL lkp1_unexpected: observed valid=1 expected no result");
        end
        if (q_lkp1.size() > 0) last1 = q_lkp1.pop_front();
      end
      chk_lkp(1, last1);
      if (cfg_rvalid) begin
        n_cmp++;
        assert (q_cfg.size() > 0) else begin
          n_fail++;
          $error("FAIL cfg_unexpected: observed rvalid=1 expected no response");
        end
        if (q_cfg.size() > 0) begin
          cfg_exp_t e;
          e = q_cfg.pop_front();
          chk("cfg_rdata",  cfg_rdata,        e.rdata);
          chk("cfg_err",    64'(cfg_err),     64'(e.err));
          chk("cfg_update", 64'(cfg_update),  64'(e.upd));
        end
      end else begin
        chk("cfg_idle_update", 64'(cfg_update), 64'd0);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rvalid", 64'(cfg_rvalid),  64'd0);
    chk("rst_rdata",  cfg_rdata,        64'd0);
    chk("rst_err",    64'(cfg_err),     64'd0);
    chk("rst_update", 64'(cfg_update),  64'd0);
    chk("rst_lvalid", 64'(lkp_valid_o), 64'd0);
    chk("rst_hit",    64'(lkp_hit_o),   64'd0);
    chk("rst_rule",   64'(lkp_rule_o),  64'd0);
    chk("rst_attr",   64'(lkp_attr_o),  64'h11);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset-image hits on both ports
    drive_lkp(0, 64'h8000_0010, 1'b1, 4'd0, 4'b1110);
    drive_lkp(1, 64'h0001_8000, 1'b1, 4'd1, 4'b1000);
    tick();
    // Misses: one past rule 0, and a gap address
    drive_lkp(0, 64'hC000_0000, 1'b0, 4'd0, 4'b0001);
    drive_lkp(1, 64'h0000_5000, 1'b0, 4'd0, 4'b0001);
    tick();
    // Last address inside rule 0 and inside rule 2
    drive_lkp(0, 64'hBFFF_FFFF, 1'b1, 4'd0, 4'b1110);
    drive_lkp(1, 64'h0000_0FFF, 1'b1, 4'd2, 4'b1001);
    tick();
    tick();

    // Program rule 3 overlapping rule 0; rule 0 keeps priority
    drive_cfg(1'b1, 3'd3, 2'd0, 64'h8000_0000, 64'd0, 1'b0); tick();
    drive_cfg(1'b1, 3'd3, 2'd1, 64'h0000_1000, 64'd0, 1'b0); tick();
    drive_cfg(1'b1, 3'd3, 2'd2, 64'h0000_0001, 64'd0, 1'b0); tick();
    drive_lkp(0, 64'h8000_0800, 1'b1, 4'd0, 4'b1110);
    drive_cfg(1'b0, 3'd3, 2'd2, 64'd0, 64'h0000_0001, 1'b0);
    tick();
    drive_cfg(1'b0, 3'd3, 2'd1, 64'd0, 64'h0000_1000, 1'b0); tick();

    // Lock rule 1, then further writes are rejected
    drive_cfg(1'b1, 3'd1, 2'd2, 64'h81, 64'd0, 1'b0); tick();
    drive_lkp(1, 64'h0001_0000, 1'b1, 4'd1, 4'b0001);
    drive_cfg(1'b0, 3'd1, 2'd2, 64'd0, 64'h81, 1'b0);
    tick();
    drive_cfg(1'b1, 3'd1, 2'd0, 64'h0, 64'd0, 1'b1); tick();
    drive_cfg(1'b1, 3'd1, 2'd2, 64'h08, 64'd0, 1'b1); tick();
    drive_cfg(1'b0, 3'd1, 2'd0, 64'd0, 64'h0001_0000, 1'b0); tick();

    // Bad index and reserved field
    drive_cfg(1'b0, 3'd4, 2'd0, 64'd0, 64'd0, 1'b1); tick();
    drive_cfg(1'b0, 3'd0, 2'd3, 64'd0, 64'd0, 1'b1); tick();
    drive_cfg(1'b1, 3'd7, 2'd1, 64'h55, 64'd0, 1'b1); tick();

    // Rule 2 at the top of the address space must not wrap to zero
    drive_cfg(1'b1, 3'd2, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 64'd0, 1'b0); tick();
    drive_cfg(1'b1, 3'd2, 2'd1, 64'h0000_0000_0000_2000, 64'd0, 1'b0); tick();
    drive_lkp(0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 4'd2, 4'b1001);
    drive_lkp(1, 64'h0, 1'b0, 4'd0, 4'b0001);
    tick();
    drive_lkp(0, 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd0, 4'b0001);
    tick();

    // Write and lookup in the same cycle: lookup sees the old table
    drive_cfg(1'b1, 3'd0, 2'd1, 64'h0, 64'd0, 1'b0);
    drive_lkp(1, 64'h8000_0000, 1'b1, 4'd0, 4'b1110);
    tick();
    drive_lkp(1, 64'h8000_0000, 1'b1, 4'd3, 4'b0001);
    drive_lkp(0, 64'h8000_2000, 1'b0, 4'd0, 4'b0001);
    tick();
    tick();

    // Reset while a lookup result and a config response are outstanding
    drive_lkp(0, 64'h8000_0010, 1'b1, 4'd3, 4'b0001);
    drive_cfg(1'b0, 3'd0, 2'd0, 64'd0, 64'h8000_0000, 1'b0);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    cfg_req   = 1'b0;
    lkp_valid = '0;
    q_lkp0.delete();
    q_lkp1.delete();
    q_cfg.delete();
    #1;
    chk("midrst_rvalid", 64'(cfg_rvalid),  64'd0);
    chk("midrst_lvalid", 64'(lkp_valid_o), 64'd0);
    chk("midrst_attr",   64'(lkp_attr_o),  64'h11);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // Table back at reset image, lock cleared
    drive_cfg(1'b0, 3'd0, 2'd1, 64'd0, 64'h4000_0000, 1'b0); tick();
    drive_cfg(1'b1, 3'd1, 2'd0, 64'h0002_0000, 64'd0, 1'b0); tick();
    drive_lkp(0, 64'h0002_0000, 1'b1, 4'd1, 4'b1000);
    drive_lkp(1, 64'h8000_0000, 1'b1, 4'd0, 4'b1110);
    tick();
    tick();
    tick();

    chk("drain_lkp0", 64'(q_lkp0.size()), 64'd0);
    chk("drain_lkp1", 64'(q_lkp1.size()), 64'd0);
    chk("drain_cfg",  64'(q_cfg.size()),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
